// File: rtl/register_file_pkg.sv
// Shared register-file types: 5-bit architectural address, the zero register,
// and RV32I ABI register names for benches and surrounding pipeline code.
package register_file_pkg;
    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_RA   = 5'd1;
    localparam reg_addr_t REG_SP   = 5'd2;
    localparam reg_addr_t REG_GP   = 5'd3;
    localparam reg_addr_t REG_TP   = 5'd4;
    localparam reg_addr_t REG_T0   = 5'd5;
    localparam reg_addr_t REG_T1   = 5'd6;
    localparam reg_addr_t REG_T2   = 5'd7;
    localparam reg_addr_t REG_S0   = 5'd8;
    localparam reg_addr_t REG_S1   = 5'd9;
    localparam reg_addr_t REG_A0   = 5'd10;
    localparam reg_addr_t REG_A1   = 5'd11;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-result scoreboard: one bit per register, issue-set beats write-back-clear,
// registered any_pending, and hazard lookup for two read addresses.
module rf_scoreboard
    import register_file_pkg::*;
#(
    parameter  int R = 32,
    localparam int A = $clog2(R)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue_ena,
    input  logic [A-1:0] issue_rd,
    input  logic         clr_ena,
    input  logic [A-1:0] clr_addr,
    input  logic [A-1:0] rd_addr_a,
    input  logic [A-1:0] rd_addr_b,
    output logic         hazard_a,
    output logic         hazard_b,
    output logic         any_pending
);
    logic [R-1:0] pending;
    logic [R-1:0] pending_nxt;

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        pending_nxt = pending;
        if (clr_ena && clr_addr != A'(REG_ZERO))
            pending_nxt[clr_addr] = 1'b0;
        if (issue_ena && issue_rd != A'(REG_ZERO))
            pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending     <= '0;
            any_pending <= 1'b0;
        end else begin
            pending     <= pending_nxt;
            any_pending <= |pending_nxt;
        end
    end

    assign hazard_a = pending[rd_addr_a];
    assign hazard_b = pending[rd_addr_b];
endmodule

// File: rtl/register_file.sv
// RV32I architectural register file: 2 async read ports, 1 sync write port, pending scoreboard.
// Optional same-cycle write-back bypass enabled by defining REGFILE_BYPASS_EN.
module register_file
    import register_file_pkg::*;
#(
    parameter  int N = 32,
    parameter  int R = 32,
    localparam int A = $clog2(R)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [A-1:0] rs1_addr,
    output logic [N-1:0] rs1_data,
    input  logic [A-1:0] rs2_addr,
    output logic [N-1:0] rs2_data,
    input  logic         rs2_used,
    input  logic         wr_ena,
    input  logic [A-1:0] wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic         issue_ena,
    input  logic [A-1:0] issue_rd,
    output logic         stall,
    output logic         any_pending
);
    logic [N-1:0] regs [R];
    logic         wr_live;
    logic         byp1, byp2;
    logic         hz1, hz2;

    assign wr_live = wr_ena && (wr_addr != A'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < R; i++)
                regs[i] <= '0;
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp1 = wr_live && (wr_addr == rs1_addr);
    assign byp2 = wr_live && (wr_addr == rs2_addr);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // x0 reads zero even if the array entry were ever disturbed.
    always_comb begin
        rs1_data = (rs1_addr == A'(REG_ZERO)) ? '0 : regs[rs1_addr];
        rs2_data = (rs2_addr == A'(REG_ZERO)) ? '0 : regs[rs2_addr];
        if (byp1) rs1_data = wr_data;
        if (byp2) rs2_data = wr_data;
    end

    rf_scoreboard #(.R(R)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .issue_ena  (issue_ena),
        .issue_rd   (issue_rd),
        .clr_ena    (wr_ena),
        .clr_addr   (wr_addr),
        .rd_addr_a  (rs1_addr),
        .rd_addr_b  (rs2_addr),
        .hazard_a   (hz1),
        .hazard_b   (hz2),
        .any_pending(any_pending)
    );

    assign stall = (hz1 & ~byp1) | (rs2_used & hz2 & ~byp2);
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: array/scoreboard model checked every cycle,
// plus literal expectations at each test-plan step.
module tb_register_file;
    import register_file_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    reg_addr_t   rs1_addr, rs2_addr, wr_addr, issue_rd;
    logic [31:0] rs1_data, rs2_data, wr_data;
    logic        rs2_used, wr_ena, issue_ena, stall, any_pending;

    int errs = 0;
    int checks = 0;

    register_file dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_used(rs2_used),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_ena(issue_ena), .issue_rd(issue_rd),
        .stall(stall), .any_pending(any_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: plain arrays updated by the architectural rules at each edge.
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_any;
    bit          m_ok = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            foreach (m_regs[i]) begin m_regs[i] = 32'd0; m_pend[i] = 1'b0; end
            m_any = 1'b0;
            m_ok  = 1'b1;
        end else begin
            if (wr_ena && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (issue_ena && issue_rd != 0) m_pend[issue_rd] = 1'b1;
            m_any = 1'b0;
            foreach (m_pend[i]) if (m_pend[i]) m_any = 1'b1;
        end
    end

    function automatic logic [31:0] exp_data(input reg_addr_t a);
        logic [31:0] d;
        d = (a == 0) ? 32'd0 : m_regs[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_ena && wr_addr != 0 && wr_addr == a) d = wr_data;
`endif
        return d;
    endfunction

    function automatic bit exp_hz(input reg_addr_t a);
        bit h;
        h = (a != 0) && m_pend[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_ena && wr_addr != 0 && wr_addr == a) h = 1'b0;
`endif
        return h;
    endfunction

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cmp rs1_data", rs1_data, exp_data(rs1_addr));
            chk("cmp rs2_data", rs2_data, exp_data(rs2_addr));
            chk("cmp stall", {31'd0, stall},
                {31'd0, exp_hz(rs1_addr) | (rs2_used & exp_hz(rs2_addr))});
            chk("cmp any_pending", {31'd0, any_pending}, {31'd0, m_any});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_ena = 1'b0; issue_ena = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rs1_addr = '0; rs2_addr = '0; rs2_used = 1'b0;
        wr_ena = 1'b0; wr_addr = '0; wr_data = '0; issue_ena = 1'b0; issue_rd = '0;
        step(); step();
        rst = 1'b1;
        rs2_used = 1'b1;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = reg_addr_t'(a);
            rs2_addr = reg_addr_t'(31 - a);
            @(negedge clk);
            chk("reset rs1_data", rs1_data, 32'd0);
            chk("reset rs2_data", rs2_data, 32'd0);
            chk("reset stall", {31'd0, stall}, 32'd0);
            chk("reset any_pending", {31'd0, any_pending}, 32'd0);
        end

        // write x5, read both ports next cycle
        @(posedge clk); #1;
        wr_ena = 1'b1; wr_addr = REG_T0; wr_data = 32'hDEADBEEF;
        step(); idle();
        rs1_addr = REG_T0; rs2_addr = REG_T0;
        @(negedge clk);
        chk("x5 rs1", rs1_data, 32'hDEADBEEF);
        chk("x5 rs2", rs2_data, 32'hDEADBEEF);

        // write to x0 is discarded
        step();
        wr_ena = 1'b1; wr_addr = REG_ZERO; wr_data = 32'h1234;
        step(); idle();
        rs1_addr = REG_ZERO; rs2_addr = REG_ZERO;
        @(negedge clk);
        chk("x0 rs1", rs1_data, 32'd0);
        chk("x0 rs2", rs2_data, 32'd0);

        // issue x7 then write back
        step();
        issue_ena = 1'b1; issue_rd = REG_T2;
        step(); idle();
        rs1_addr = REG_T2; rs2_used = 1'b0;
        @(negedge clk);
        chk("x7 pending stall", {31'd0, stall}, 32'd1);
        chk("x7 any_pending", {31'd0, any_pending}, 32'd1);
        step();
        wr_ena = 1'b1; wr_addr = REG_T2; wr_data = 32'h55;
        step(); idle();
        @(negedge clk);
        chk("x7 wb stall", {31'd0, stall}, 32'd0);
        chk("x7 wb data", rs1_data, 32'h55);
        chk("x7 wb any_pending", {31'd0, any_pending}, 32'd0);

        // write-back while reading a pending register
        step();
        issue_ena = 1'b1; issue_rd = REG_T2;
        step(); idle();
        wr_ena = 1'b1; wr_addr = REG_T2; wr_data = 32'hAA;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        chk("bypass data", rs1_data, 32'hAA);
        chk("bypass stall", {31'd0, stall}, 32'd0);
`else
        chk("nobypass data", rs1_data, 32'h55);
        chk("nobypass stall", {31'd0, stall}, 32'd1);
`endif
        step(); idle();
        @(negedge clk);
        chk("after wb data", rs1_data, 32'hAA);
        chk("after wb stall", {31'd0, stall}, 32'd0);

        // issue and write back x9 on the same edge: set wins
        step();
        issue_ena = 1'b1; issue_rd = REG_S1;
        wr_ena = 1'b1; wr_addr = REG_S1; wr_data = 32'h99;
        step(); idle();
        rs1_addr = REG_ZERO; rs2_addr = REG_S1; rs2_used = 1'b0;
        @(negedge clk);
        chk("x9 unused stall", {31'd0, stall}, 32'd0);
        chk("x9 any_pending", {31'd0, any_pending}, 32'd1);
        step();
        rs2_used = 1'b1;
        @(negedge clk);
        chk("x9 used stall", {31'd0, stall}, 32'd1);
        chk("x9 data", rs2_data, 32'h99);

        // mid-operation reset discards pending bits and data
        step();
        issue_ena = 1'b1; issue_rd = REG_GP; step();
        issue_rd = REG_TP; step();
        issue_rd = REG_T0; step();
        idle();
        rs1_addr = REG_GP; rs2_addr = REG_TP;
        @(negedge clk);
        chk("pre-reset stall", {31'd0, stall}, 32'd1);
        step();
        rst = 1'b0; issue_ena = 1'b1; issue_rd = REG_A0;
        wr_ena = 1'b1; wr_addr = REG_A0; wr_data = 32'h77;
        step();
        rst = 1'b1; idle();
        rs1_addr = REG_T0; rs2_addr = REG_A0;
        @(negedge clk);
        chk("post-reset any_pending", {31'd0, any_pending}, 32'd0);
        chk("post-reset stall", {31'd0, stall}, 32'd0);
        chk("post-reset x5", rs1_data, 32'd0);
        chk("post-reset x10", rs2_data, 32'd0);
        rs1_addr = REG_GP; rs2_addr = REG_TP;
        @(negedge clk);
        chk("post-reset stall x3/x4", {31'd0, stall}, 32'd0);

        step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
